// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and the raw/aligned flag bundle.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } vga_flags_t;

    // Blanked, sync idle: what the pins show before any real pixel arrives.
    localparam vga_flags_t FLAGS_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};
endpackage

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter: enabled up-counter 0..MAX; wrap flags the enabled cycle at MAX.
module vga_wrap_counter #(
    parameter int WIDTH = 16,
    parameter int MAX   = 799
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    assign wrap = en && (count == WIDTH'(MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + WIDTH'(1);
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA counters, sync/blank flags and pin-aligned RGB.
// Define PIXEL_DIV_EN for a 25 MHz pixel strobe from clk with 1-pixel pin latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACT   = H_ACTIVE,
    parameter int H_FRONT = H_FP,
    parameter int H_PULSE = H_SYNC,
    parameter int H_BACK  = H_BP,
    parameter int V_ACT   = V_ACTIVE,
    parameter int V_FRONT = V_FP,
    parameter int V_PULSE = V_SYNC,
    parameter int V_BACK  = V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  Red_in,
    input  logic [3:0]  Green_in,
    input  logic [3:0]  Blue_in,
    output logic [15:0] Xpos,
    output logic [15:0] Ypos,
    output logic        pix_en,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);
    localparam int H_TOT = H_ACT + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOT = V_ACT + V_FRONT + V_PULSE + V_BACK;

    logic       x_wrap;
    logic       y_wrap;
    vga_flags_t raw;
    vga_flags_t pin_src;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pix_en <= 1'b0;
        else
`ifdef PIXEL_DIV_EN
            pix_en <= ~pix_en;
`else
            pix_en <= 1'b1;
`endif
    end

    vga_wrap_counter #(.WIDTH(16), .MAX(H_TOT - 1)) u_x (
        .clk   (clk),
        .rst   (rst),
        .en    (pix_en),
        .count (Xpos),
        .wrap  (x_wrap)
    );

    vga_wrap_counter #(.WIDTH(16), .MAX(V_TOT - 1)) u_y (
        .clk   (clk),
        .rst   (rst),
        .en    (x_wrap),
        .count (Ypos),
        .wrap  (y_wrap)
    );

    assign raw = '{
        active: (Xpos < 16'(H_ACT)) && (Ypos < 16'(V_ACT)),
        hs:     !((Xpos >= 16'(H_ACT + H_FRONT)) && (Xpos < 16'(H_ACT + H_FRONT + H_PULSE))),
        vs:     !((Ypos >= 16'(V_ACT + V_FRONT)) && (Ypos < 16'(V_ACT + V_FRONT + V_PULSE)))
    };

`ifdef PIXEL_DIV_EN
    assign pin_src = raw;
`else
    // Extra pixel of delay lines the flags up with a colour stage that registers once.
    vga_flags_t s1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            s1 <= FLAGS_IDLE;
        else if (pix_en)
            s1 <= raw;
    end
    assign pin_src = s1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_start <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            frame_start <= y_wrap;
            if (pix_en) begin
                hsync    <= pin_src.hs;
                vsync    <= pin_src.vs;
                video_on <= pin_src.active;
                vga_r    <= pin_src.active ? Red_in   : '0;
                vga_g    <= pin_src.active ? Green_in : '0;
                vga_b    <= pin_src.active ? Blue_in  : '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench; instance 0 uses the real 640x480 timing,
// instance 1 a tiny geometry so frame wrap and vsync are exercised in a short run.
module tb_vga_timing_gen;
`ifdef PIXEL_DIV_EN
    localparam bit DIV = 1'b1;
    localparam int LAT = 1;
`else
    localparam bit DIV = 1'b0;
    localparam int LAT = 2;
`endif
    localparam int HA [2] = '{640, 8};
    localparam int HF [2] = '{16, 2};
    localparam int HS [2] = '{96, 3};
    localparam int HB [2] = '{48, 3};
    localparam int VA [2] = '{480, 6};
    localparam int VF [2] = '{10, 2};
    localparam int VS [2] = '{2, 2};
    localparam int VB [2] = '{33, 3};

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        pe;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        von;
        logic [11:0] rgb;
    } obs_t;

    localparam obs_t RST_OBS = '{x: 16'd0, y: 16'd0, pe: 1'b0, fs: 1'b0,
                                 hs: 1'b1, vs: 1'b1, von: 1'b0, rgb: 12'h000};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
    logic [15:0] xp [2];
    logic [15:0] yp [2];
    logic        pe [2], fs [2], hs [2], vs [2], von [2];
    logic [3:0]  vr [2], vg [2], vb [2];

    int   checks = 0;
    int   failures = 0;
    obs_t q [2][$];
    obs_t m [2];
    int   j [2];
    longint p [2];
    int   fs_exp [2] = '{0, 0};
    int   fs_act [2] = '{0, 0};

    always #5 clk = ~clk;

    vga_timing_gen u_d0 (
        .clk(clk), .rst(rst), .Red_in(r_in), .Green_in(g_in), .Blue_in(b_in),
        .Xpos(xp[0]), .Ypos(yp[0]), .pix_en(pe[0]), .frame_start(fs[0]),
        .hsync(hs[0]), .vsync(vs[0]), .video_on(von[0]),
        .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0])
    );

    vga_timing_gen #(
        .H_ACT(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(3),
        .V_ACT(6), .V_FRONT(2), .V_PULSE(2), .V_BACK(3)
    ) u_d1 (
        .clk(clk), .rst(rst), .Red_in(r_in), .Green_in(g_in), .Blue_in(b_in),
        .Xpos(xp[1]), .Ypos(yp[1]), .pix_en(pe[1]), .frame_start(fs[1]),
        .hsync(hs[1]), .vsync(vs[1]), .video_on(von[1]),
        .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1])
    );

    function automatic obs_t actual(int i);
        return '{x: xp[i], y: yp[i], pe: pe[i], fs: fs[i], hs: hs[i], vs: vs[i],
                 von: von[i], rgb: {vr[i], vg[i], vb[i]}};
    endfunction

    // Reference: after p pixel strobes the count is p, and the pins show pixel p-LAT.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int  htot, vtot, cx, cy;
            bit  pb;
            longint c;
            htot = HA[i] + HF[i] + HS[i] + HB[i];
            vtot = VA[i] + VF[i] + VS[i] + VB[i];
            if (!rst) begin
                j[i] = 0;
                p[i] = 0;
                m[i] = RST_OBS;
            end else begin
                pb = (j[i] >= 1) && (DIV ? (j[i] % 2 == 1) : 1'b1);
                j[i]++;
                m[i].fs = 1'b0;
                if (pb) begin
                    p[i]++;
                    m[i].x = 16'(p[i] % htot);
                    m[i].y = 16'((p[i] / htot) % vtot);
                    m[i].fs = (p[i] % (htot * vtot)) == 0;
                    if (p[i] >= LAT) begin
                        c  = p[i] - LAT;
                        cx = int'(c % htot);
                        cy = int'((c / htot) % vtot);
                        m[i].von = (cx < HA[i]) && (cy < VA[i]);
                        m[i].hs  = !(cx >= HA[i] + HF[i] && cx < HA[i] + HF[i] + HS[i]);
                        m[i].vs  = !(cy >= VA[i] + VF[i] && cy < VA[i] + VF[i] + VS[i]);
                        m[i].rgb = m[i].von ? {r_in, g_in, b_in} : 12'h000;
                    end
                end
                m[i].pe = DIV ? (j[i] % 2 == 1) : 1'b1;
                if (m[i].fs) fs_exp[i]++;
            end
            q[i].push_back(m[i]);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            obs_t a, e;
            if (q[i].size() != 0) begin
                e = q[i].pop_front();
                a = actual(i);
                if (a.fs) fs_act[i]++;
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL obs inst%0d t=%0t act x=%0d y=%0d pe=%b fs=%b hs=%b vs=%b von=%b rgb=%h req x=%0d y=%0d pe=%b fs=%b hs=%b vs=%b von=%b rgb=%h",
                             i, $time, a.x, a.y, a.pe, a.fs, a.hs, a.vs, a.von, a.rgb,
                             e.x, e.y, e.pe, e.fs, e.hs, e.vs, e.von, e.rgb);
                end
            end
        end
    end

    task automatic check_reset();
        for (int i = 0; i < 2; i++) begin
            obs_t a;
            a = actual(i);
            checks++;
            if (a !== RST_OBS) begin
                failures++;
                $display("FAIL rst_async inst%0d act x=%0d y=%0d pe=%b fs=%b hs=%b vs=%b von=%b rgb=%h req reset values",
                         i, a.x, a.y, a.pe, a.fs, a.hs, a.vs, a.von, a.rgb);
            end
        end
    endtask

    task automatic run(int n, bit full);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
            if (failures > 50) break;
            r_in = full ? 4'hF : 4'($urandom);
            g_in = full ? 4'hF : 4'($urandom);
            b_in = full ? 4'hF : 4'($urandom);
        end
    endtask

    task automatic pulse_reset(int len);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset();
        repeat (len) @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_reset();
        rst = 1'b1;
        run(3000, 1'b0);
        pulse_reset(int'($urandom_range(1, 3)));
        run(2500, 1'b1);
        pulse_reset(1);
        run(int'($urandom_range(1000, 4000)), 1'b0);
        pulse_reset(int'($urandom_range(1, 3)));
        run(60000, 1'b0);
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (fs_act[i] != fs_exp[i]) begin
                failures++;
                $display("FAIL fs_count inst%0d act=%0d req=%0d", i, fs_act[i], fs_exp[i]);
            end
        end
        checks++;
        if (fs_exp[1] == 0) begin
            failures++;
            $display("FAIL fs_seen inst1 act=0 req>0");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
